uart_cmd_bridge: RTL and testbench
==================================

# uart_cmd_bridge

Parametrised UART command processor that turns a host byte stream into GPIO accesses and word accesses on a generic memory request bus, such as an SDRAM controller front-end. It sits between the UART byte transceiver and the memory controller and the debug pin banks. It generalises the fixed-width bridge with:
- configurable pin-bank count, address width and data width;
- auto-incrementing bursts of up to 256 words in either direction;
- flow-controlled transmit;
- sticky error status.

## Interface
Parameters:
- N_PINS, 8: number of 8-bit input and output pin banks (1..16).
- ADDR_W, 24: memory word-address width (8..32).
- DATA_BYTES, 2: memory word width in bytes (1..4).
- TIMEOUT_CYC, 50000: idle cycles allowed between argument bytes before abort.

Ports (reset sys_rst_n, asynchronous, active-low; clock sys_clk):
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_valid  out  1  byte offered to the transmitter.
- tx_ready  in  1  transmitter accepts; a transfer occurs when tx_valid && tx_ready.
- tx_data  out  8  byte to send.
- in_pin  in  8*N_PINS  input banks; bank i is [8i+7:8i].
- out_pin  out  8*N_PINS  output banks.
- out_clk  out  1  software-driven clock line.
- out_rst  out  1  software-driven reset line.
- mem_req  out  1  request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  word address; stable while mem_req.
- mem_wdata  out  8*DATA_BYTES  write data; stable while mem_req.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  8*DATA_BYTES  read data; valid in the mem_ack cycle.

## Operation
Multi-byte fields are sent and returned LSB first. AB = ceil(ADDR_W/8). Opcodes:
- 0x10/0x11: out_clk <= 1/0.
- 0x12/0x13: out_rst <= 1/0.
- 0x20+i: send in_pin bank i (1 byte).
- 0x30+i: the next byte is written to out_pin bank i.
  - For both, i >= N_PINS is treated as an unknown opcode.
- 0x40: load address pointer from the next AB bytes. Bits of the top byte above ADDR_W are ignored.
- 0xA0: single write. Collect DATA_BYTES bytes, write them at the pointer, then increment the pointer.
- 0xA1: single read. Read at the pointer, send DATA_BYTES bytes, then increment the pointer.
- 0xA2 L: burst write of L+1 words. Collect DATA_BYTES bytes, write, increment; repeat.
- 0xA3 L: burst read of L+1 words. Read, send DATA_BYTES bytes, increment; repeat. The next request issues only after the last byte of the previous word has been accepted.
- 0xB0: send the status byte, then clear it. Bit0 = rx byte dropped, bit1 = argument timeout, bit2 = unknown opcode, bits7:3 = 0.
- Any other opcode: set status bit2, return to IDLE, send nothing.

State machine:
- IDLE: an rx byte is taken as the opcode. Go to ARG if argument bytes are needed; else to MEM, TX, or complete in one cycle.
- ARG: count bytes. When the last one arrives, go to MEM (write/read) or IDLE (address/pin write).
- MEM: assert mem_req and wait for mem_ack. Reads capture mem_rdata into a word buffer.
- TX: shift the word buffer out one byte per accepted transfer.
  - When done, return to MEM if the burst count remains (read), ARG if it remains (write), else IDLE.
  - Burst write returns to ARG after each MEM.

Rules:
- The address pointer wraps modulo 2^ADDR_W and persists across commands.
- Burst count is 8 bits; L = 0 means one word.
- rx bytes arriving in MEM or TX are dropped and set status bit0.
- Reset mid-operation: all state returns to IDLE and outputs go to reset values. The memory side must tolerate mem_req deasserting before mem_ack.

## Timing
- Reset values: tx_valid 0, tx_data 0, out_pin 0, out_clk 0, out_rst 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, pointer 0, status 0.
- Pin/clk/rst commands: the output changes on the clock edge after the completing rx_valid cycle.
- Read commands: tx_valid rises on the clock edge after the opcode byte (pins/status) or after mem_ack (memory).
- tx_data must not change while tx_valid && !tx_ready.
- mem_req rises one cycle after the last argument byte (or after the last tx transfer, for burst reads). It falls on the cycle after mem_ack. Minimum of one idle cycle between requests.
- The pointer increments in the cycle after mem_ack.
- mem_ack while mem_req = 0 is ignored.

## Configuration
- UART_CMD_BRIDGE_TIMEOUT_EN defined: a 32-bit counter runs in ARG and is reloaded on each rx byte. When it reaches TIMEOUT_CYC, the block aborts to IDLE, sets status bit1, and discards partial data; no memory access occurs.
- Not defined: no counter; ARG waits indefinitely, and status bit1 always reads 0.

## Structure
- Package uart_cmd_bridge_pkg holds:
  - opcode localparams (OP_CLK_HI … OP_STATUS);
  - the state enum (IDLE, ARG, MEM, TX);
  - status bit indices.
- One sub-module, uart_cmd_txser: loads a word buffer of up to 4 bytes with a byte count and performs the tx_valid/tx_ready shift-out. It reports done in the cycle of the last accepted transfer.

## Test plan
- 0x31, 0x5A with N_PINS=8 -> out_pin[15:8]=0x5A, no tx. Then 0x21 with in_pin[15:8]=0xC3 -> a single tx byte 0xC3.
- 0x40 03 02 01, 0xA0 34 12 -> one mem request with we=1, addr 0x010203, wdata 0x1234. Then 0xA1 -> read at 0x010204, tx 2 bytes LSB first.
- 0x40 FF FF FF, 0xA3 02, memory returns 0x1111/0x2222/0x3333 -> addresses 0xFFFFFF, 0x000000, 0x000001 (wrap); tx 11 11 22 22 33 33, with tx_ready held low for 5 cycles mid-burst and no byte lost.
- 0xA2 01 then 4 bytes, with rx bytes injected during MEM -> two writes. 0xB0 then returns 0x01, and a second 0xB0 returns 0x00.
- With TIMEOUT_EN, TIMEOUT_CYC=100: 0xA0 0x34 then silence -> abort after 100 cycles with no mem_req; 0xB0 returns 0x02. Opcode 0x77 -> 0xB0 returns 0x04.
- Assert reset during burst-read TX -> all outputs at reset values next cycle; a following 0x20 command works normally.

Source files
------------

// File: rtl/uart_cmd_bridge_pkg.sv
// uart_cmd_bridge_pkg: opcodes, FSM state and status bit positions
// shared by the UART command bridge and its transmit serialiser.
package uart_cmd_bridge_pkg;

   localparam logic [7:0] OP_CLK_HI = 8'h10;
   localparam logic [7:0] OP_CLK_LO = 8'h11;
   localparam logic [7:0] OP_RST_HI = 8'h12;
   localparam logic [7:0] OP_RST_LO = 8'h13;
   localparam logic [7:0] OP_PIN_RD = 8'h20;
   localparam logic [7:0] OP_PIN_WR = 8'h30;
   localparam logic [7:0] OP_ADDR   = 8'h40;
   localparam logic [7:0] OP_WR     = 8'hA0;
   localparam logic [7:0] OP_RD     = 8'hA1;
   localparam logic [7:0] OP_BWR    = 8'hA2;
   localparam logic [7:0] OP_BRD    = 8'hA3;
   localparam logic [7:0] OP_STATUS = 8'hB0;

   typedef enum logic [1:0] {
      IDLE,
      ARG,
      MEM,
      TX
   } state_t;

   localparam int ST_DROP = 0;
   localparam int ST_TMO  = 1;
   localparam int ST_UNK  = 2;

endpackage

// File: rtl/uart_cmd_bridge_txser.sv
// uart_cmd_txser: shifts a loaded word out LSB first over a
// valid/ready byte channel; done marks the last accepted byte.
module uart_cmd_txser (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        load,
   input  logic [31:0] word,
   input  logic [2:0]  nbytes,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        done
);

   logic [23:0] rest;
   logic [2:0]  left;
   logic        xfer;

   assign xfer = tx_valid && tx_ready;
   assign done = xfer && (left == 3'd0);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         rest     <= '0;
         left     <= 3'd0;
      end else if (load) begin
         tx_valid <= 1'b1;
         tx_data  <= word[7:0];
         rest     <= word[31:8];
         left     <= nbytes - 3'd1;
      end else if (xfer) begin
         if (left == 3'd0) begin
            tx_valid <= 1'b0;
         end else begin
            tx_data <= rest[7:0];
            rest    <= {8'h00, rest[23:8]};
            left    <= left - 3'd1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: UART command processor driving pin banks and a word bus.
// Define UART_CMD_BRIDGE_TIMEOUT_EN to abort stalled argument phases.
module uart_cmd_bridge
   import uart_cmd_bridge_pkg::*;
#(
   parameter int N_PINS      = 8,
   parameter int ADDR_W      = 24,
   parameter int DATA_BYTES  = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [7:0]              tx_data,
   input  logic [8*N_PINS-1:0]     in_pin,
   output logic [8*N_PINS-1:0]     out_pin,
   output logic                    out_clk,
   output logic                    out_rst,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*DATA_BYTES-1:0] mem_wdata,
   input  logic                    mem_ack,
   input  logic [8*DATA_BYTES-1:0] mem_rdata
);

   localparam int AB    = (ADDR_W + 7) / 8;
   localparam int DW    = 8 * DATA_BYTES;
   localparam int ARG_N = (AB > DATA_BYTES) ? AB : DATA_BYTES;

   state_t             state, state_nx;
   logic [7:0]         op, burst, pin_sel;
   logic [1:0]         cnt;
   logic               have_len;
   logic [8*ARG_N-1:0] arg, arg_nx;
   logic [ADDR_W-1:0]  ptr;
   logic [2:0]         status, need;
   logic               last_arg, pin_ok, ack, tmo_hit;
   logic               is_ctl, is_pin_rd, is_pin_wr, is_arg;
   logic               is_rd, is_stat, is_bad;
   logic               tx_load, tx_done;
   logic [31:0]        tx_word;
   logic [2:0]         tx_cnt;

   assign ack       = mem_ack && mem_req;
   assign pin_ok    = int'(rx_data[3:0]) < N_PINS;
   assign is_ctl    = rx_data[7:2] == OP_CLK_HI[7:2];
   assign is_pin_rd = (rx_data[7:4] == OP_PIN_RD[7:4]) && pin_ok;
   assign is_pin_wr = (rx_data[7:4] == OP_PIN_WR[7:4]) && pin_ok;
   assign is_arg    = is_pin_wr || rx_data == OP_ADDR || rx_data == OP_WR
                   || rx_data == OP_BWR || rx_data == OP_BRD;
   assign is_rd     = rx_data == OP_RD;
   assign is_stat   = rx_data == OP_STATUS;
   assign is_bad    = !(is_ctl || is_pin_rd || is_arg || is_rd || is_stat);

   always_comb begin
      need = 3'd1;
      if (op == OP_ADDR)
         need = 3'(AB);
      else if (op == OP_WR || (op == OP_BWR && have_len))
         need = 3'(DATA_BYTES);
   end

   assign last_arg = ({1'b0, cnt} == need - 3'd1);

   always_comb begin
      arg_nx  = arg;
      pin_sel = 8'h00;
      for (int k = 0; k < ARG_N; k++)
         if (cnt == 2'(k)) arg_nx[8*k +: 8] = rx_data;
      for (int k = 0; k < N_PINS; k++)
         if (rx_data[3:0] == 4'(k)) pin_sel = in_pin[8*k +: 8];
   end

`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
   logic [31:0] tmo;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         tmo <= '0;
      else if (state != ARG || rx_valid)
         tmo <= '0;
      else
         tmo <= tmo + 32'd1;
   end

   assign tmo_hit = (state == ARG) && !rx_valid
                 && (tmo == 32'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      tx_load  = 1'b0;
      tx_word  = '0;
      tx_cnt   = 3'd1;
      unique case (state)
         IDLE: if (rx_valid) begin
            unique case (1'b1)
               is_pin_rd: begin
                  tx_load  = 1'b1;
                  tx_word  = 32'(pin_sel);
                  state_nx = TX;
               end
               is_stat: begin
                  tx_load  = 1'b1;
                  tx_word  = 32'(status);
                  state_nx = TX;
               end
               is_rd:   state_nx = MEM;
               is_arg:  state_nx = ARG;
               default: state_nx = IDLE;
            endcase
         end
         ARG: begin
            if (tmo_hit) begin
               state_nx = IDLE;
            end else if (rx_valid && last_arg) begin
               if (op == OP_BRD || op == OP_WR || (op == OP_BWR && have_len))
                  state_nx = MEM;
               else if (op != OP_BWR)
                  state_nx = IDLE;
            end
         end
         MEM: if (ack) begin
            if (!mem_we) begin
               tx_load  = 1'b1;
               tx_word  = 32'(mem_rdata);
               tx_cnt   = 3'(DATA_BYTES);
               state_nx = TX;
            end else if (burst != 8'd0) begin
               state_nx = ARG;
            end else begin
               state_nx = IDLE;
            end
         end
         TX: if (tx_done)
            state_nx = (op == OP_BRD && burst != 8'd0) ? MEM : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         op        <= 8'h00;
         burst     <= 8'h00;
         cnt       <= 2'd0;
         have_len  <= 1'b0;
         arg       <= '0;
         ptr       <= '0;
         status    <= 3'd0;
         out_pin   <= '0;
         out_clk   <= 1'b0;
         out_rst   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (rx_valid && (state == MEM || state == TX))
            status[ST_DROP] <= 1'b1;
         unique case (state)
            IDLE: if (rx_valid) begin
               op       <= rx_data;
               cnt      <= 2'd0;
               have_len <= 1'b0;
               burst    <= 8'h00;
               if (rx_data == OP_CLK_HI) out_clk <= 1'b1;
               if (rx_data == OP_CLK_LO) out_clk <= 1'b0;
               if (rx_data == OP_RST_HI) out_rst <= 1'b1;
               if (rx_data == OP_RST_LO) out_rst <= 1'b0;
               if (is_stat) status <= 3'd0;
               if (is_bad)  status[ST_UNK] <= 1'b1;
               if (is_rd) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= ptr;
               end
            end
            ARG: begin
               if (tmo_hit) begin
                  status[ST_TMO] <= 1'b1;
                  cnt            <= 2'd0;
               end else if (rx_valid) begin
                  arg <= arg_nx;
                  cnt <= cnt + 2'd1;
                  if (last_arg) begin
                     cnt <= 2'd0;
                     if (op[7:4] == OP_PIN_WR[7:4]) begin
                        for (int k = 0; k < N_PINS; k++)
                           if (op[3:0] == 4'(k)) out_pin[8*k +: 8] <= rx_data;
                     end else if (op == OP_ADDR) begin
                        ptr <= arg_nx[ADDR_W-1:0];
                     end else if (op == OP_BRD || (op == OP_BWR && !have_len)) begin
                        burst    <= rx_data;
                        have_len <= 1'b1;
                        if (op == OP_BRD) begin
                           mem_req  <= 1'b1;
                           mem_we   <= 1'b0;
                           mem_addr <= ptr;
                        end
                     end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= arg_nx[DW-1:0];
                     end
                  end
               end
            end
            MEM: if (ack) begin
               mem_req <= 1'b0;
               ptr     <= ptr + ADDR_W'(1);
               if (mem_we && burst != 8'd0) burst <= burst - 8'd1;
            end
            TX: if (tx_done && op == OP_BRD && burst != 8'd0) begin
               // next burst word is requested only once the last byte left
               burst    <= burst - 8'd1;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= ptr;
            end
            default: ;
         endcase
      end
   end

   uart_cmd_txser u_txser (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (tx_load),
      .word      (tx_word),
      .nbytes    (tx_cnt),
      .tx_ready  (tx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .done      (tx_done)
   );

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed vectors for the UART command bridge
// with a simple acknowledging memory model and tx byte capture.
module tb_uart_cmd_bridge;

   localparam int N_PINS      = 8;
   localparam int ADDR_W      = 24;
   localparam int DATA_BYTES  = 2;
   localparam int TIMEOUT_CYC = 100;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        rx_valid  = 1'b0;
   logic [7:0]  rx_data   = 8'h00;
   logic        tx_valid;
   logic        tx_ready  = 1'b1;
   logic [7:0]  tx_data;
   logic [63:0] in_pin    = 64'h8877_6655_4433_C311;
   logic [63:0] out_pin;
   logic        out_clk, out_rst, mem_req, mem_we;
   logic [23:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack   = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;

   int checks = 0;
   int failures = 0;
   int lat = 0;
   int stall_err = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0]  txq[$];
   logic [15:0] rdq[$];
   logic [40:0] memq[$];

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      int          nb;
      int          ntx;
      logic [7:0]  tx;
      logic [63:0] pins;
      logic        clk;
      logic        rst;
   } vec_t;

   vec_t vt[15];

   uart_cmd_bridge #(
      .N_PINS      (N_PINS),
      .ADDR_W      (ADDR_W),
      .DATA_BYTES  (DATA_BYTES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .in_pin    (in_pin),
      .out_pin   (out_pin),
      .out_clk   (out_clk),
      .out_rst   (out_rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (tx_valid && tx_ready) txq.push_back(tx_data);
         if (prev_stall && tx_data !== prev_data) stall_err++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   // acknowledges each request on the third falling edge it is seen
   always @(negedge sys_clk) begin
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req) begin
         if (lat == 2) begin
            lat     = 0;
            mem_ack = 1'b1;
            memq.push_back({mem_we, mem_addr, mem_wdata});
            if (!mem_we) begin
               if (rdq.size() > 0) mem_rdata = rdq.pop_front();
               else                mem_rdata = 16'h0000;
            end
         end else begin
            lat++;
         end
      end else begin
         lat = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge sys_clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge sys_clk);
      rx_valid = 1'b0;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] txpack();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < txq.size() && i < 8; i++) v[8*i +: 8] = txq[i];
      return v;
   endfunction

   task automatic chk_tx(input string name, input int n,
                         input logic [63:0] exp);
      chk({name, "_n"}, 64'(txq.size()), 64'(n));
      chk({name, "_d"}, txpack(), exp);
      txq.delete();
   endtask

   task automatic chk_mem(input string name, input logic we,
                          input logic [23:0] addr, input logic [15:0] wd);
      logic [40:0] v;
      v = '1;
      if (memq.size() > 0) v = memq.pop_front();
      if (we) chk(name, 64'(v), 64'({we, addr, wd}));
      else    chk(name, 64'(v[40:16]), 64'({we, addr}));
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_txv"}, 64'(tx_valid), 64'd0);
      chk({p, "_txd"}, 64'(tx_data), 64'd0);
      chk({p, "_pin"}, out_pin, 64'd0);
      chk({p, "_clk"}, 64'(out_clk), 64'd0);
      chk({p, "_rst"}, 64'(out_rst), 64'd0);
      chk({p, "_req"}, 64'(mem_req), 64'd0);
      chk({p, "_we"}, 64'(mem_we), 64'd0);
      chk({p, "_addr"}, 64'(mem_addr), 64'd0);
      chk({p, "_wd"}, 64'(mem_wdata), 64'd0);
   endtask

   initial begin
      vt[0]  = '{8'h31, 8'h5A, 2, 0, 8'h00, 64'h0000_0000_0000_5A00, 1'b0, 1'b0};
      vt[1]  = '{8'h21, 8'h00, 1, 1, 8'hC3, 64'h0000_0000_0000_5A00, 1'b0, 1'b0};
      vt[2]  = '{8'h10, 8'h00, 1, 0, 8'h00, 64'h0000_0000_0000_5A00, 1'b1, 1'b0};
      vt[3]  = '{8'h12, 8'h00, 1, 0, 8'h00, 64'h0000_0000_0000_5A00, 1'b1, 1'b1};
      vt[4]  = '{8'h37, 8'hA5, 2, 0, 8'h00, 64'hA500_0000_0000_5A00, 1'b1, 1'b1};
      vt[5]  = '{8'h27, 8'h00, 1, 1, 8'h88, 64'hA500_0000_0000_5A00, 1'b1, 1'b1};
      vt[6]  = '{8'h11, 8'h00, 1, 0, 8'h00, 64'hA500_0000_0000_5A00, 1'b0, 1'b1};
      vt[7]  = '{8'h13, 8'h00, 1, 0, 8'h00, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[8]  = '{8'h28, 8'h00, 1, 0, 8'h00, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[9]  = '{8'h38, 8'h00, 1, 0, 8'h00, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[10] = '{8'hB0, 8'h00, 1, 1, 8'h04, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[11] = '{8'hB0, 8'h00, 1, 1, 8'h00, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[12] = '{8'h20, 8'h00, 1, 1, 8'h11, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[13] = '{8'h55, 8'h00, 1, 0, 8'h00, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};
      vt[14] = '{8'hB0, 8'h00, 1, 1, 8'h04, 64'hA500_0000_0000_5A00, 1'b0, 1'b0};

      tick(3);
      chk_rst("reset");
      sys_rst_n = 1'b1;
      tick(2);

      for (int i = 0; i < 15; i++) begin
         send(vt[i].b0);
         if (vt[i].nb == 2) send(vt[i].b1);
         chk($sformatf("v%0d_txv", i), 64'(tx_valid), 64'(vt[i].ntx != 0));
         chk($sformatf("v%0d_pin", i), out_pin, vt[i].pins);
         chk($sformatf("v%0d_clk", i), 64'(out_clk), 64'(vt[i].clk));
         chk($sformatf("v%0d_rst", i), 64'(out_rst), 64'(vt[i].rst));
         tick(6);
         chk_tx($sformatf("v%0d_tx", i), vt[i].ntx, 64'(vt[i].tx));
      end

      // single write then single read
      send(8'h40); send(8'h03); send(8'h02); send(8'h01);
      send(8'hA0); send(8'h34); send(8'h12);
      chk("a_req_rise", 64'(mem_req), 64'd1);
      tick(10);
      chk_mem("a_wr", 1'b1, 24'h010203, 16'h1234);
      rdq.push_back(16'hBEEF);
      send(8'hA1);
      tick(10);
      chk_mem("a_rd", 1'b0, 24'h010204, 16'h0000);
      chk_tx("a_rd_tx", 2, 64'hBEEF);

      // burst read across the address wrap, with a transmit stall
      send(8'h40); send(8'hFF); send(8'hFF); send(8'hFF);
      rdq.push_back(16'h1111); rdq.push_back(16'h2222); rdq.push_back(16'h3333);
      send(8'hA3); send(8'h02);
      for (int i = 0; i < 60 && txq.size() < 3; i++) @(negedge sys_clk);
      chk("b_got3", 64'(txq.size() >= 3), 64'd1);
      tx_ready = 1'b0;
      tick(5);
      chk("b_stall_n", 64'(txq.size()), 64'd3);
      tx_ready = 1'b1;
      tick(30);
      chk_mem("b_rd0", 1'b0, 24'hFFFFFF, 16'h0000);
      chk_mem("b_rd1", 1'b0, 24'h000000, 16'h0000);
      chk_mem("b_rd2", 1'b0, 24'h000001, 16'h0000);
      chk_tx("b_tx", 6, 64'h3333_2222_1111);
      chk("b_stable", 64'(stall_err), 64'd0);

      // burst write with a byte injected during the memory phase
      send(8'hA2); send(8'h01); send(8'h78); send(8'h56);
      chk("c_req", 64'(mem_req), 64'd1);
      rx_valid = 1'b1;
      rx_data  = 8'hEE;
      @(negedge sys_clk);
      rx_valid = 1'b0;
      tick(8);
      send(8'hBC); send(8'h9A);
      tick(10);
      chk_mem("c_wr0", 1'b1, 24'h000002, 16'h5678);
      chk_mem("c_wr1", 1'b1, 24'h000003, 16'h9ABC);
      chk("c_nomore", 64'(memq.size()), 64'd0);
      send(8'hB0); tick(6);
      chk_tx("c_st1", 1, 64'h01);
      send(8'hB0); tick(6);
      chk_tx("c_st2", 1, 64'h00);

      // stalled argument phase
      send(8'hA0); send(8'h34);
      tick(150);
      chk("d_noreq", 64'(memq.size()), 64'd0);
`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
      send(8'hB0); tick(6);
      chk_tx("d_st", 1, 64'h02);
`else
      send(8'h12); tick(10);
      chk_mem("d_wr", 1'b1, 24'h000004, 16'h1234);
      send(8'hB0); tick(6);
      chk_tx("d_st", 1, 64'h00);
`endif
      send(8'h77); tick(2);
      send(8'hB0); tick(6);
      chk_tx("e_st", 1, 64'h04);

      // reset in the middle of a stalled burst read
      send(8'h10);
      rdq.push_back(16'hAAAA); rdq.push_back(16'hBBBB);
      tx_ready = 1'b0;
      send(8'hA3); send(8'h01);
      for (int i = 0; i < 30 && !tx_valid; i++) @(negedge sys_clk);
      chk("f_txv", 64'(tx_valid), 64'd1);
      sys_rst_n = 1'b0;
      #1;
      chk_rst("f_rst");
      tick(2);
      rdq.delete(); txq.delete(); memq.delete();
      tx_ready  = 1'b1;
      sys_rst_n = 1'b1;
      tick(2);
      send(8'h20);
      chk("f_pin_txv", 64'(tx_valid), 64'd1);
      tick(6);
      chk_tx("f_pin_tx", 1, 64'h11);
      rdq.push_back(16'h4321);
      send(8'hA1);
      tick(10);
      chk_mem("f_rd", 1'b0, 24'h000000, 16'h0000);
      chk_tx("f_rd_tx", 2, 64'h4321);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
